// File: rtl/fprd_reconstruct.sv
// Sequential shift-add inverse of the restoring divider: rebuilds dividend = quot*divisor + rem,
// consuming one quotient bit per clock behind a start/busy/done handshake.
module fprd_reconstruct #(
    parameter int QW = 4,
    parameter int DW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [QW-1:0]    quot,
    input  logic [DW-1:0]    divisor,
    input  logic [DW-1:0]    rem,
    output logic             busy,
    output logic             done,
    output logic [QW+DW-1:0] dividend,
    output logic             div0,
    output logic             rem_err
);

    localparam int RW = QW + DW;
    localparam int CW = (QW > 1) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nxt;
    logic [QW-1:0] q, q_nxt;
    logic [RW-1:0] acc, acc_nxt;
    logic [RW-1:0] mcand, mcand_nxt;
    logic [RW-1:0] sum;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [RW-1:0] dividend_nxt;
    logic          div0_nxt, rem_err_nxt;

    // acc starts at rem so the remainder is folded in without a final add
    always_comb begin
        state_nxt    = state;
        q_nxt        = q;
        acc_nxt      = acc;
        mcand_nxt    = mcand;
        cnt_nxt      = cnt;
        dividend_nxt = dividend;
        div0_nxt     = div0;
        rem_err_nxt  = rem_err;
        sum          = acc + (q[0] ? mcand : '0);

        case (state)
            IDLE: begin
                if (start) begin
                    q_nxt       = quot;
                    acc_nxt     = {{QW{1'b0}}, rem};
                    mcand_nxt   = {{QW{1'b0}}, divisor};
                    cnt_nxt     = '0;
                    div0_nxt    = (divisor == '0);
                    rem_err_nxt = (divisor != '0) && (rem >= divisor);
                    state_nxt   = RUN;
                end
            end
            RUN: begin
                acc_nxt   = sum;
                q_nxt     = q >> 1;
                mcand_nxt = mcand << 1;
                cnt_nxt   = cnt + 1'b1;
                if (cnt == CW'(QW - 1)) begin
                    dividend_nxt = sum;
                    state_nxt    = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // busy/done are registered from the next state so they line up with it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            q        <= '0;
            acc      <= '0;
            mcand    <= '0;
            cnt      <= '0;
            dividend <= '0;
            div0     <= 1'b0;
            rem_err  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            q        <= q_nxt;
            acc      <= acc_nxt;
            mcand    <= mcand_nxt;
            cnt      <= cnt_nxt;
            dividend <= dividend_nxt;
            div0     <= div0_nxt;
            rem_err  <= rem_err_nxt;
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_fprd_reconstruct.sv
// Self-checking bench for fprd_reconstruct: cycle-level arithmetic model compared every
// negedge, plus directed literal expectations and an exhaustive sweep of all inputs.
module tb_fprd_reconstruct;

    localparam int QW = 4;
    localparam int DW = 4;
    localparam int RW = QW + DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [QW-1:0] quot = '0;
    logic [DW-1:0] divisor = '0;
    logic [DW-1:0] rem = '0;
    logic          busy, done, div0, rem_err;
    logic [RW-1:0] dividend;

    int tests = 0;
    int fails = 0;
    bit compareOn = 1'b0;

    always #5 clk = ~clk;

    fprd_reconstruct #(.QW(QW), .DW(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .quot     (quot),
        .divisor  (divisor),
        .rem      (rem),
        .busy     (busy),
        .done     (done),
        .dividend (dividend),
        .div0     (div0),
        .rem_err  (rem_err)
    );

    // Model: a phase count since acceptance; the result is plain q*d+r
    int            mPhase;
    logic [RW-1:0] mDividend;
    logic          mDiv0, mRemErr;
    logic [QW-1:0] lq;
    logic [DW-1:0] ld, lr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPhase    <= 0;
            mDividend <= '0;
            mDiv0     <= 1'b0;
            mRemErr   <= 1'b0;
            lq        <= '0;
            ld        <= '0;
            lr        <= '0;
        end else if (mPhase == 0) begin
            if (start) begin
                lq      <= quot;
                ld      <= divisor;
                lr      <= rem;
                mDiv0   <= (divisor == 0);
                mRemErr <= (divisor != 0) && (rem >= divisor);
                mPhase  <= 1;
            end
        end else if (mPhase == QW) begin
            mDividend <= RW'(int'(lq) * int'(ld) + int'(lr));
            mPhase    <= QW + 1;
        end else if (mPhase == QW + 1) begin
            mPhase <= 0;
        end else begin
            mPhase <= mPhase + 1;
        end
    end

    logic expBusy, expDone;

    always @(negedge clk) begin
        if (compareOn) begin
            expBusy = (mPhase != 0);
            expDone = (mPhase == QW + 1);
            tests++;
            if ({busy, done, dividend, div0, rem_err} !==
                {expBusy, expDone, mDividend, mDiv0, mRemErr}) begin
                fails++;
                $display("[TB] FAIL cycle-model t=%0t busy/done/dividend/div0/rem_err got %b/%b/%h/%b/%b want %b/%b/%h/%b/%b",
                         $time, busy, done, dividend, div0, rem_err,
                         expBusy, expDone, mDividend, mDiv0, mRemErr);
            end
        end
    end

    task automatic checkValue(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s got %0d want %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input logic [RW-1:0] expDividend,
                               input logic expDiv0, input logic expRemErr);
        tests++;
        if ({dividend, div0, rem_err} !== {expDividend, expDiv0, expRemErr}) begin
            fails++;
            $display("[TB] FAIL %s dividend/div0/rem_err got %h/%b/%b want %h/%b/%b",
                     name, dividend, div0, rem_err, expDividend, expDiv0, expRemErr);
        end
    endtask

    // Accept one operation, scramble inputs during RUN, and return at the done negedge
    task automatic applyStimulus(input logic [QW-1:0] q, input logic [DW-1:0] d,
                                 input logic [DW-1:0] r);
        int lat;
        @(posedge clk);
        #1;
        quot    = q;
        divisor = d;
        rem     = r;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        quot    = ~q;
        divisor = ~d;
        rem     = ~r;
        lat     = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
        checkValue("latency", lat, QW + 1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        compareOn = 1'b1;
        #2;
        checkOutput("reset-state", 8'h00, 1'b0, 1'b0);
        checkValue("reset-busy", int'(busy), 0);
        checkValue("reset-done", int'(done), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        applyStimulus(4'b0010, 4'b0101, 4'b0011);
        checkOutput("t1", 8'h0D, 1'b0, 1'b0);
        applyStimulus(4'b1111, 4'b1111, 4'b1110);
        checkOutput("t2", 8'hEF, 1'b0, 1'b0);
        applyStimulus(4'b1010, 4'b0000, 4'b0111);
        checkOutput("t3-div0", 8'h07, 1'b1, 1'b0);
        applyStimulus(4'b0000, 4'b0011, 4'b0010);
        checkOutput("quot-zero", 8'h02, 1'b0, 1'b0);
        applyStimulus(4'b0001, 4'b0101, 4'b0110);
        checkOutput("t4-remerr", 8'h0B, 1'b0, 1'b1);

        // start held high: two back-to-back operations with one IDLE cycle between
        @(posedge clk);
        #1;
        quot    = 4'b0101;
        divisor = 4'b0011;
        rem     = 4'b0010;
        start   = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checkValue($sformatf("held-done k=%0d", k), int'(done), (k == 5 || k == 11) ? 1 : 0);
            checkValue($sformatf("held-busy k=%0d", k), int'(busy), (k == 6 || k == 12) ? 0 : 1);
        end
        start = 1'b0;
        checkOutput("held-result", 8'h11, 1'b0, 1'b0);

        // reset in the middle of RUN aborts without a done pulse
        @(posedge clk);
        #1;
        quot    = 4'b1111;
        divisor = 4'b0011;
        rem     = 4'b0101;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort-outputs", 8'h00, 1'b0, 1'b0);
        checkValue("abort-busy", int'(busy), 0);
        repeat (2) begin
            @(negedge clk);
            checkValue("abort-no-done", int'(done), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            checkValue("post-abort-no-done", int'(done), 0);
            checkValue("post-abort-busy", int'(busy), 0);
        end
        applyStimulus(4'b0011, 4'b0100, 4'b0001);
        checkOutput("after-abort", 8'h0D, 1'b0, 1'b0);

        for (int q = 0; q < 16; q++) begin
            for (int d = 0; d < 16; d++) begin
                for (int r = 0; r < 16; r++) begin
                    applyStimulus(QW'(q), DW'(d), DW'(r));
                    checkOutput($sformatf("sweep q=%0d d=%0d r=%0d", q, d, r),
                                RW'(q * d + r), (d == 0), (d != 0) && (r >= d));
                end
            end
        end

        @(posedge clk);
        @(negedge clk);
        compareOn = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
